// File: rtl/mips_pkg.sv
// mips_pkg: shared encodings and scoreboard entry type for the pipeline hazard controller
package mips_pkg;

    localparam int RA_W = 5;

    typedef enum logic [1:0] {
        FWD_RF    = 2'b00,
        FWD_EXMEM = 2'b01,
        FWD_MEMWB = 2'b10
    } fwd_e;

    typedef enum logic [1:0] {
        ST_RUN        = 2'b00,
        ST_MEM_WAIT   = 2'b01,
        ST_FLUSH_PEND = 2'b10
    } state_e;

    typedef struct packed {
        logic            v;
        logic [RA_W-1:0] dst;
        logic [RA_W-1:0] rs;
        logic [RA_W-1:0] rt;
        logic            reg_write;
        logic            mem_read;
    } sb_entry_t;

    // Nearest producer wins: the EX/MEM result is newer than the MEM/WB one.
    function automatic fwd_e fwd_sel(input sb_entry_t mem, input sb_entry_t wb, input logic [RA_W-1:0] src);
        return (mem.v && mem.reg_write && mem.dst != '0 && mem.dst == src) ? FWD_EXMEM :
               (wb.v && wb.reg_write && wb.dst != '0 && wb.dst == src)    ? FWD_MEMWB : FWD_RF;
    endfunction

    // A load in EX whose destination is read by the instruction in ID cannot be forwarded in time.
    function automatic logic load_use_hit(input sb_entry_t ex, input sb_entry_t id, input logic uses_rt);
        return id.v && ex.v && ex.mem_read && ex.dst != '0 &&
               (ex.dst == id.rs || (uses_rt && ex.dst == id.rt));
    endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: in-flight EX/MEM/WB destination tracking with forwarding and load-use detection
module hazard_scoreboard
    import mips_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       adv_i,
    input  logic       kill_i,
    input  sb_entry_t  id_i,
    input  logic       id_uses_rt_i,
    output logic       load_use_o,
    output logic [1:0] fwd_a_o,
    output logic [1:0] fwd_b_o
);

    sb_entry_t ex_q, mem_q, wb_q;

    // Shift one stage per advance; a bubble or flush enters EX as an all-zero NOP
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else if (adv_i) begin
            ex_q  <= kill_i ? '0 : id_i;
            mem_q <= ex_q;
            wb_q  <= mem_q;
        end
    end

    assign fwd_a_o    = fwd_sel(mem_q, wb_q, ex_q.rs);
    assign fwd_b_o    = fwd_sel(mem_q, wb_q, ex_q.rt);
    assign load_use_o = load_use_hit(ex_q, id_i, id_uses_rt_i);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush sequencing, memory wait handling and counters for a 5-stage MIPS pipeline
module pipeline_hazard_ctrl
    import mips_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [RA_W-1:0]  id_rs,
    input  logic [RA_W-1:0]  id_rt,
    input  logic             id_uses_rt,
    input  logic [RA_W-1:0]  id_dst,
    input  logic             id_reg_write,
    input  logic             id_mem_read,
    input  logic             ex_branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             if_id_flush,
    output logic             id_ex_bubble,
    output logic             ex_mem_en,
    output logic             mem_wb_en,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count,
    output logic             mem_timeout
);

    localparam int WT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WT_W-1:0] WT_MAX = WT_W'(MEM_TIMEOUT);

    state_e          state_q, state_d;
    logic            pend_q, pend_d, tout_q, tout_d;
    logic [WT_W-1:0] wait_q, wait_d;
    logic [CNT_W-1:0] stall_q, stall_d, flush_q, flush_d;
    logic            hold, flush, lu_stall, load_use, br;
    sb_entry_t       id_ent;

    assign id_ent = '{v: id_valid, dst: id_dst, rs: id_rs, rt: id_rt,
                      reg_write: id_reg_write, mem_read: id_mem_read};

    hazard_scoreboard u_sb (
        .clk          (clk),
        .reset        (reset),
        .adv_i        (!hold),
        .kill_i       (flush || lu_stall),
        .id_i         (id_ent),
        .id_uses_rt_i (id_uses_rt),
        .load_use_o   (load_use),
        .fwd_a_o      (fwd_a),
        .fwd_b_o      (fwd_b)
    );

    // Next state: a memory stall outranks a flush (which is deferred), and a flush discards any load-use stall
    always_comb begin
        state_d  = state_q;
        pend_d   = pend_q;
        wait_d   = wait_q;
        hold     = 1'b0;
        flush    = 1'b0;
        lu_stall = 1'b0;
        br       = ex_branch_taken || state_q == ST_FLUSH_PEND;
        if (state_q != ST_MEM_WAIT) begin
            hold     = mem_req && !mem_ready;
            state_d  = hold ? ST_MEM_WAIT : ST_RUN;
            pend_d   = hold && br;
            wait_d   = WT_W'(1);
            flush    = !hold && br;
            lu_stall = !hold && !br && load_use;
        end else begin
            hold    = !mem_ready;
            pend_d  = pend_q || ex_branch_taken;
            state_d = hold ? ST_MEM_WAIT : pend_d ? ST_FLUSH_PEND : ST_RUN;
            wait_d  = (hold && wait_q != WT_MAX) ? wait_q + 1'b1 : wait_q;
        end
        tout_d  = tout_q || (hold && wait_d == WT_MAX);
        stall_d = (!pc_en && stall_q != '1) ? stall_q + 1'b1 : stall_q;
        flush_d = (flush && flush_q != '1) ? flush_q + 1'b1 : flush_q;
    end

    // State, pending-flush latch, wait timer and saturating counters
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_RUN;
            pend_q  <= 1'b0;
            wait_q  <= '0;
            tout_q  <= 1'b0;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            wait_q  <= wait_d;
            tout_q  <= tout_d;
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

    assign pc_en        = !hold && !lu_stall;
    assign if_id_en     = !hold && !lu_stall;
    assign if_id_flush  = flush;
    assign id_ex_bubble = flush || lu_stall;
    assign ex_mem_en    = !hold;
    assign mem_wb_en    = !hold;
    assign stall_cycles = stall_q;
    assign flush_count  = flush_q;
    assign mem_timeout  = tout_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: scoreboard bench with a per-cycle behavioural model of the hazard rules
module tb_pipeline_hazard_ctrl;

    localparam int CNT_W       = 4;
    localparam int MEM_TIMEOUT = 4;
    localparam int CMAX        = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic id_valid = 1'b0, id_uses_rt = 1'b0, id_reg_write = 1'b0, id_mem_read = 1'b0;
    logic ex_branch_taken = 1'b0, mem_req = 1'b0, mem_ready = 1'b0;
    logic [4:0] id_rs = '0, id_rt = '0, id_dst = '0;
    logic pc_en, if_id_en, if_id_flush, id_ex_bubble, ex_mem_en, mem_wb_en, mem_timeout;
    logic [1:0] fwd_a, fwd_b;
    logic [CNT_W-1:0] stall_cycles, flush_count;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rt(id_uses_rt), .id_dst(id_dst), .id_reg_write(id_reg_write),
        .id_mem_read(id_mem_read), .ex_branch_taken(ex_branch_taken), .mem_req(mem_req),
        .mem_ready(mem_ready), .pc_en(pc_en), .if_id_en(if_id_en), .if_id_flush(if_id_flush),
        .id_ex_bubble(id_ex_bubble), .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_cycles(stall_cycles), .flush_count(flush_count),
        .mem_timeout(mem_timeout)
    );

    typedef struct packed {
        logic v;
        logic [4:0] dst, rs, rt;
        logic rw, mr;
    } ins_t;

    // pipe[0]=EX, pipe[1]=MEM, pipe[2]=WB instruction; a bubble is an all-zero NOP
    ins_t pipe [3];
    bit waiting, flush_due, tout;
    int wait_n, stalls, flushes;
    logic [18:0] expq [$];
    int checks = 0, failures = 0, cyc_no = 0;

    task automatic model_reset();
        for (int i = 0; i < 3; i++) pipe[i] = '0;
        waiting = 0; flush_due = 0; tout = 0; wait_n = 0; stalls = 0; flushes = 0;
    endtask

    function automatic logic [1:0] src_of(input logic [4:0] r);
        if (r != 0 && pipe[1].v && pipe[1].rw && pipe[1].dst == r) return 2'b01;
        if (r != 0 && pipe[2].v && pipe[2].rw && pipe[2].dst == r) return 2'b10;
        return 2'b00;
    endfunction

    // One clock of stimulus; k: 0 memory stall, 1 flush, 2 load-use stall, 3 normal advance
    task automatic cyc(input bit rst, input bit v, input int rs, input int rt, input bit urt,
                       input int dst, input bit rw, input bit mr, input bit br, input bit mreq, input bit mrdy);
        ins_t id;
        bit lu;
        int k;
        @(posedge clk);
        #1;
        reset = rst; id_valid = v; id_rs = rs[4:0]; id_rt = rt[4:0]; id_uses_rt = urt;
        id_dst = dst[4:0]; id_reg_write = rw; id_mem_read = mr;
        ex_branch_taken = br; mem_req = mreq; mem_ready = mrdy;
        if (rst) begin
            model_reset();
            return;
        end
        id = '{v, dst[4:0], rs[4:0], rt[4:0], rw, mr};
        lu = v && pipe[0].v && pipe[0].mr && pipe[0].dst != 0 &&
             (pipe[0].dst == rs[4:0] || (urt && pipe[0].dst == rt[4:0]));
        if (waiting) k = mrdy ? 3 : 0;
        else k = (mreq && !mrdy) ? 0 : (flush_due || br) ? 1 : lu ? 2 : 3;
        expq.push_back({k == 1 || k == 3, k == 1 || k == 3, k == 1, k == 1 || k == 2, k != 0, k != 0,
                        src_of(pipe[0].rs), src_of(pipe[0].rt), CNT_W'(stalls), CNT_W'(flushes), tout});
        if (k == 0) begin
            wait_n = waiting ? wait_n + 1 : 1;
            if (wait_n >= MEM_TIMEOUT) tout = 1;
            if (br) flush_due = 1;
            waiting = 1;
        end else begin
            if (waiting) begin
                if (br) flush_due = 1;
                waiting = 0;
            end else flush_due = 0;
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            pipe[0] = (k == 3) ? id : '0;
        end
        if ((k == 0 || k == 2) && stalls < CMAX) stalls++;
        if (k == 1 && flushes < CMAX) flushes++;
    endtask

    task automatic quiet(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: compares the DUT outputs mid-cycle against the expectation pushed for that cycle
    initial begin
        logic [18:0] act, exp_v;
        forever begin
            @(negedge clk);
            cyc_no++;
            if (expq.size() > 0) begin
                exp_v = expq.pop_front();
                act = {pc_en, if_id_en, if_id_flush, id_ex_bubble, ex_mem_en, mem_wb_en,
                       fwd_a, fwd_b, stall_cycles, flush_count, mem_timeout};
                checks++;
                if (act !== exp_v) begin
                    failures++;
                    $display("FAIL outputs cycle %0d got=%b required=%b (pc,ifid,flush,bub,exm,mwb,fa,fb,stall,flush_cnt,tout)",
                             cyc_no, act, exp_v);
                end
            end
        end
    end

    initial begin
        model_reset();
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        quiet(2);
        // lw $2 ; add $3,$2,$4 (stalls once, then re-presented)
        cyc(0, 1, 1, 0, 0, 2, 1, 1, 0, 0, 0);
        cyc(0, 1, 2, 4, 1, 3, 1, 0, 0, 0, 0);
        cyc(0, 1, 2, 4, 1, 3, 1, 0, 0, 0, 0);
        quiet(3);
        // add $5 ; sub $6,$5,$5
        cyc(0, 1, 1, 2, 1, 5, 1, 0, 0, 0, 0);
        cyc(0, 1, 5, 5, 1, 6, 1, 0, 0, 0, 0);
        quiet(3);
        // writes and loads to $0 followed by readers of $0
        cyc(0, 1, 1, 2, 1, 0, 1, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 1, 7, 1, 0, 0, 0, 0);
        cyc(0, 1, 1, 0, 0, 0, 1, 1, 0, 0, 0);
        cyc(0, 1, 0, 0, 1, 8, 1, 0, 0, 0, 0);
        quiet(3);
        // three-cycle memory wait
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        quiet(2);
        // taken branch latched during a wait, applied after release
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        quiet(3);
        // plain taken branch discarding a load-use stall in the same cycle
        cyc(0, 1, 1, 0, 0, 9, 1, 1, 0, 0, 0);
        cyc(0, 1, 9, 0, 0, 3, 1, 0, 1, 0, 0);
        quiet(3);
        // timeout: six low cycles, then sticky until reset
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        quiet(3);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        quiet(2);
        // counter saturation
        for (int i = 0; i < CMAX + 3; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        for (int i = 0; i < CMAX + 3; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        quiet(2);
        // randomized traffic with occasional resets, including mid-wait
        for (int i = 0; i < 4000; i++) begin
            bit mreq;
            mreq = waiting ? 1'b1 : ($urandom_range(0, 4) == 0);
            cyc($urandom_range(0, 79) == 0, $urandom_range(0, 3) != 0,
                $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 1) == 1,
                $urandom_range(0, 3), $urandom_range(0, 2) != 0, $urandom_range(0, 2) == 0,
                $urandom_range(0, 7) == 0, mreq, $urandom_range(0, 2) == 0);
        end
        quiet(1);
        @(posedge clk);
        @(posedge clk);
        checks++;
        if (expq.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d required=0", expq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
